// File: rtl/btn_debounce.sv
// Purpose: two-flop synchroniser plus per-button stability filter with press (and optional release) strobes; release strobe under `BTN_RELEASE_PULSE_EN.
// Latency: an input change stable before edge k appears on btn_db at edge k+1+DB_CYCLES, with the strobe in the same cycle.
// Backpressure: none; free-running level filter, strobes are single-cycle and never held.
module btn_debounce #(
    parameter int N_BTN     = 5,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_db,
`ifdef BTN_RELEASE_PULSE_EN
    output logic [N_BTN-1:0] btn_release,
`endif
    output logic [N_BTN-1:0] btn_press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    if (DB_CYCLES < 2) begin : gBadParam
        $error("btn_debounce: DB_CYCLES must be >= 2");
    end

    logic [N_BTN-1:0] sync1;
    logic [N_BTN-1:0] sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_in;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : gChan
        logic [CNT_W-1:0] cnt;
        logic             dbLvl;
        logic             pressPulse;
`ifdef BTN_RELEASE_PULSE_EN
        logic             releasePulse;
`endif

        // Any sample that agrees with the accepted level restarts the count.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt        <= '0;
                dbLvl      <= 1'b0;
                pressPulse <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                releasePulse <= 1'b0;
`endif
            end else begin
                pressPulse <= 1'b0;
`ifdef BTN_RELEASE_PULSE_EN
                releasePulse <= 1'b0;
`endif
                if (sync2[i] == dbLvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt        <= '0;
                    dbLvl      <= sync2[i];
                    pressPulse <= sync2[i];
`ifdef BTN_RELEASE_PULSE_EN
                    releasePulse <= ~sync2[i];
`endif
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end

        assign btn_db[i]    = dbLvl;
        assign btn_press[i] = pressPulse;
`ifdef BTN_RELEASE_PULSE_EN
        assign btn_release[i] = releasePulse;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed and randomised bench for btn_debounce (DB_CYCLES=4); a sliding-window
// stability model predicts the debounced levels and strobes every cycle.
module tb_btn_debounce;

    localparam int N  = 5;
    localparam int DB = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = '1;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_press;
`ifdef BTN_RELEASE_PULSE_EN
    logic [N-1:0] btn_release;
`endif

    btn_debounce #(.N_BTN(N), .DB_CYCLES(DB)) dut (
        .clk(clk),
        .rst(rst),
        .btn_in(btn_in),
        .btn_db(btn_db),
`ifdef BTN_RELEASE_PULSE_EN
        .btn_release(btn_release),
`endif
        .btn_press(btn_press)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the last DB synchronised
    // samples all disagree with the current level; inputs reach the filter
    // two edges after they are sampled.
    logic [N-1:0] mdb, mpress, mrel;
    logic [N-1:0] inQ[$];
    logic [N-1:0] xQ[$];

    task automatic modelEdge(input logic r, input logic [N-1:0] b);
        logic [N-1:0] x;
        logic         stable;
        if (r) begin
            mdb = '0; mpress = '0; mrel = '0;
            inQ.delete(); inQ.push_back('0); inQ.push_back('0);
            xQ.delete();
        end else begin
            x = inQ.pop_front();
            inQ.push_back(b);
            xQ.push_back(x);
            if (xQ.size() > DB) void'(xQ.pop_front());
            mpress = '0; mrel = '0;
            for (int i = 0; i < N; i++) begin
                if (xQ.size() == DB) begin
                    stable = 1'b1;
                    for (int k = 0; k < DB; k++)
                        if (xQ[k][i] == mdb[i]) stable = 1'b0;
                    if (stable) begin
                        mdb[i]    = x[i];
                        mpress[i] = x[i];
                        mrel[i]   = ~x[i];
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare mid-cycle.
    task automatic step(input logic r, input logic [N-1:0] b);
        rst = r;
        btn_in = b;
        @(posedge clk);
        modelEdge(r, b);
        @(negedge clk);
        chk("model_db", btn_db, mdb);
        chk("model_press", btn_press, mpress);
`ifdef BTN_RELEASE_PULSE_EN
        chk("model_release", btn_release, mrel);
`endif
    endtask

    initial begin
        logic [N-1:0] b;
        logic [N-1:0] bounce;
        bounce = 5'b01101;   // bit1 pattern 1,0,1,1,0 read LSB first
        @(negedge clk);

        // Reset with all buttons held: outputs must stay cleared.
        for (int j = 0; j < 3; j++) begin
            step(1'b1, 5'b11111);
            chk("reset_db", btn_db, 5'b00000);
            chk("reset_press", btn_press, 5'b00000);
        end
        for (int j = 0; j < 8; j++) step(1'b0, 5'b00000);

        // Clean press on bit0: accepted on the 6th edge after it is applied.
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, 5'b00001);
            if (j < 6) chk("press0_wait_db", btn_db, 5'b00000);
            if (j < 6) chk("press0_wait_pulse", btn_press, 5'b00000);
            if (j == 6) chk("press0_db", btn_db, 5'b00001);
            if (j == 6) chk("press0_pulse", btn_press, 5'b00001);
            if (j == 7) chk("press0_single", btn_press, 5'b00000);
        end

        // Bounce on bit1, then steady high.
        for (int j = 0; j < 5; j++) begin
            step(1'b0, {3'b000, bounce[j], 1'b1});
            chk("bounce_no_pulse", btn_press, 5'b00000);
        end
        for (int j = 1; j <= 8; j++) begin
            step(1'b0, 5'b00011);
            if (j != 6) chk("bounce_pulse_other", btn_press, 5'b00000);
            if (j == 6) chk("bounce_pulse", btn_press, 5'b00010);
        end

        // Short glitch on bit2 (3 cycles) never gets accepted.
        for (int j = 0; j < 11; j++) begin
            step(1'b0, (j < 3) ? 5'b00111 : 5'b00011);
            chk("glitch_db", btn_db, 5'b00011);
            chk("glitch_pulse", btn_press, 5'b00000);
        end

        // Simultaneous rise then fall on bits 3 and 4.
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, 5'b11011);
            if (j == 6) chk("simul_press", btn_press, 5'b11000);
            if (j == 6) chk("simul_db", btn_db, 5'b11011);
        end
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, 5'b00011);
            if (j == 5) chk("simul_rel_hold", btn_db, 5'b11011);
            if (j == 6) chk("simul_rel_db", btn_db, 5'b00011);
`ifdef BTN_RELEASE_PULSE_EN
            if (j == 6) chk("simul_rel_pulse", btn_release, 5'b11000);
            if (j == 7) chk("simul_rel_single", btn_release, 5'b00000);
`endif
        end

        // Reset mid-count with bit0 held through deassertion.
        for (int j = 0; j < 8; j++) step(1'b0, 5'b00000);
        step(1'b0, 5'b00001);
        step(1'b0, 5'b00001);
        step(1'b1, 5'b00001);
        step(1'b1, 5'b00001);
        chk("midrst_db", btn_db, 5'b00000);
        for (int j = 1; j <= 7; j++) begin
            step(1'b0, 5'b00001);
            if (j < 6) chk("midrst_wait", btn_press, 5'b00000);
            if (j == 6) chk("midrst_press", btn_press, 5'b00001);
            if (j == 7) chk("midrst_single", btn_press, 5'b00000);
        end

        // Random bouncing on all channels with occasional resets.
        b = 5'b00001;
        for (int j = 0; j < 3000; j++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
